// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, receiver states and baud divisor table shared by both UART directions
package uart_pkg;
   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 16;
   localparam bit PARITY_ODD = 1'b0;
   localparam int BAUD_RATE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
   // Rounded clocks per oversample tick; only ever evaluated at elaboration
   function automatic int baud_div(input int clk_hz, input int sel);
      return (clk_hz + (OVERSAMPLE / 2) * BAUD_RATE[sel]) / (OVERSAMPLE * BAUD_RATE[sel]);
   endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO; data_o reads 0 while empty
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic [DATA_BITS-1:0] data_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 empty_o,
   output logic                 full_o
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0]        wr_q, rd_q;
   logic [AW:0]          cnt_q;
   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic                 do_push, do_pop;
   assign empty_o = cnt_q == '0;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign do_pop  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot a full-FIFO push needs
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = empty_o ? '0 : mem_q[rd_q];
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(do_push);
         rd_q  <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: 16x-oversampled 8E1 UART receiver with sticky error flags
// and a FWFT receive FIFO for the host.
module uart_rx_controller
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Rx_EN,
   input  logic       RxD,
   input  logic       Rx_RD,
   input  logic       Rx_CLR,
   output logic [7:0] Rx_DATA,
   output logic       Rx_EMPTY,
   output logic       Rx_FULL,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR,
   output logic       Rx_OVF
);
   localparam int CW = $clog2(baud_div(CLK_HZ, 0) + 1);
   localparam int DIV_TAB [8] = '{baud_div(CLK_HZ, 0), baud_div(CLK_HZ, 1), baud_div(CLK_HZ, 2),
                                  baud_div(CLK_HZ, 3), baud_div(CLK_HZ, 4), baud_div(CLK_HZ, 5),
                                  baud_div(CLK_HZ, 6), baud_div(CLK_HZ, 7)};
   rx_state_e            state_q, state_d;
   logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
   logic [2:0]           baud_q;
   logic [CW-1:0]        div, div_cnt_q, div_cnt_d;
   logic [3:0]           smp_q, smp_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
   logic                 start_det, reload, tick, centre, commit, push;
   assign div       = CW'(DIV_TAB[baud_select]);
   assign start_det = state_q == IDLE && Rx_EN && rxd_prev_q && !rxd_sync_q;
   assign reload    = baud_select != baud_q || start_det;
   assign tick      = !reload && div_cnt_q == div - CW'(1);
   assign div_cnt_d = (reload || tick) ? '0 : div_cnt_q + CW'(1);
   assign centre    = tick && smp_q == 4'(OVERSAMPLE - 1);
   always_comb begin
      state_d = state_q;
      smp_d   = tick ? smp_q + 4'd1 : smp_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: if (start_det) begin
            state_d = START;
            smp_d   = '0;
         end
         // Half a bit in: a line back high means the falling edge was a glitch
         START: if (tick && smp_q == 4'(OVERSAMPLE / 2 - 1)) begin
            state_d = rxd_sync_q ? IDLE : DATA;
            smp_d   = '0;
            bit_d   = '0;
         end
         DATA: if (centre) begin
            shift_d = {rxd_sync_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
            state_d = bit_q == 3'(DATA_BITS - 1) ? PARITY : DATA;
         end
         PARITY: if (centre) begin
            par_d   = (^{shift_q, rxd_sync_q}) != PARITY_ODD;
            state_d = STOP;
         end
         STOP: if (centre) begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!Rx_EN) begin
         state_d = IDLE;
         commit  = 1'b0;
      end
   end
   assign push   = commit && rxd_sync_q && !par_q;
   assign perr_d = (commit && par_q) || (perr_q && !Rx_CLR);
   assign ferr_d = (commit && !rxd_sync_q) || (ferr_q && !Rx_CLR);
   assign ovf_d  = (push && Rx_FULL && !(Rx_RD && !Rx_EMPTY)) || (ovf_q && !Rx_CLR);
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
         baud_q     <= '0;
         div_cnt_q  <= '0;
         state_q    <= IDLE;
         smp_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         rxd_meta_q <= RxD;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
         baud_q     <= baud_select;
         div_cnt_q  <= div_cnt_d;
         state_q    <= state_d;
         smp_q      <= smp_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovf_q      <= ovf_d;
      end
   end
   assign Rx_PERROR = perr_q;
   assign Rx_FERROR = ferr_q;
   assign Rx_OVF    = ovf_q;
   uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (Rx_RD),
      .data_i  (shift_q),
      .data_o  (Rx_DATA),
      .empty_o (Rx_EMPTY),
      .full_o  (Rx_FULL)
   );
endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: drives serial frames and checks outputs against a queue-based model
module tb_uart_rx_controller;
   localparam int CLK_HZ = 10_000_000;
   localparam int DEPTH  = 4;
   localparam int RATES [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
   logic       clk = 1'b0, reset = 1'b1;
   logic [2:0] baud_select = 3'd7;
   logic       Rx_EN = 1'b1, RxD = 1'b1, Rx_RD = 1'b0, Rx_CLR = 1'b0;
   logic [7:0] Rx_DATA;
   logic       Rx_EMPTY, Rx_FULL, Rx_PERROR, Rx_FERROR, Rx_OVF;
   int         total = 0, bad = 0, div, n;
   bit         chk_en = 1'b0;
   byte unsigned exp_q [$];
   bit         m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;
   uart_rx_controller #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
      .Rx_RD(Rx_RD), .Rx_CLR(Rx_CLR), .Rx_DATA(Rx_DATA), .Rx_EMPTY(Rx_EMPTY),
      .Rx_FULL(Rx_FULL), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR), .Rx_OVF(Rx_OVF)
   );
   always #5 clk = ~clk;
   function automatic int div_of(input int sel);
      return int'($floor(real'(CLK_HZ) / (16.0 * real'(RATES[sel])) + 0.5));
   endfunction
   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) if (chk_en) begin
      check("data", Rx_DATA, exp_q.size() != 0 ? int'(exp_q[0]) : 0);
      check("empty", Rx_EMPTY, exp_q.size() == 0);
      check("full", Rx_FULL, exp_q.size() == DEPTH);
      check("perror", Rx_PERROR, m_perr);
      check("ferror", Rx_FERROR, m_ferr);
      check("ovf", Rx_OVF, m_ovf);
   end
   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic set_baud(input int sel);
      baud_select = 3'(sel);
      div = div_of(sel);
      step(3);
   endtask
   task automatic pop();
      Rx_RD = 1'b1;
      step(1);
      Rx_RD = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
   endtask
   task automatic clr();
      Rx_CLR = 1'b1;
      step(1);
      Rx_CLR = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
   endtask
   task automatic send_frame(input byte unsigned d, input bit bad_par, input bit bad_stop);
      logic [10:0] f;
      chk_en = 1'b0;
      f = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         RxD = f[i];
         step(16 * div);
      end
      RxD = 1'b1;
      step(4);
      if (bad_stop) m_ferr = 1'b1;
      if (bad_par) m_perr = 1'b1;
      if (!bad_par && !bad_stop) begin
         if (exp_q.size() == DEPTH) m_ovf = 1'b1;
         else exp_q.push_back(d);
      end
      chk_en = 1'b1;
   endtask
   initial begin
      div = div_of(7);
      step(5);
      reset = 1'b0;
      step(1);
      check("rst_data", Rx_DATA, 0);
      check("rst_empty", Rx_EMPTY, 1);
      check("rst_full", Rx_FULL, 0);
      check("rst_perr", Rx_PERROR, 0);
      check("rst_ferr", Rx_FERROR, 0);
      check("rst_ovf", Rx_OVF, 0);
      chk_en = 1'b1;
      step(3);
      n = 0;
      fork
         send_frame(8'hA5, 1'b0, 1'b0);
         while (Rx_EMPTY && n < 200 * div) begin
            step(1);
            n++;
         end
      join
      check("a5_latency_window", int'(n >= 168 * div && n <= 168 * div + 4), 1);
      check("a5_data", Rx_DATA, 'hA5);
      check("a5_empty", Rx_EMPTY, 0);
      check("a5_perr", Rx_PERROR, 0);
      check("a5_ferr", Rx_FERROR, 0);
      pop();
      set_baud(3);
      send_frame(8'h3C, 1'b1, 1'b0);
      check("3c_perr", Rx_PERROR, 1);
      check("3c_empty", Rx_EMPTY, 1);
      clr();
      check("3c_perr_clr", Rx_PERROR, 0);
      set_baud(7);
      send_frame(8'h55, 1'b0, 1'b1);
      check("55_ferr", Rx_FERROR, 1);
      check("55_empty", Rx_EMPTY, 1);
      clr();
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
      check("ovf_full", Rx_FULL, 1);
      check("ovf_flag", Rx_OVF, 1);
      for (int i = 1; i <= 4; i++) begin
         check("ovf_pop_data", Rx_DATA, i);
         pop();
      end
      check("ovf_drained", Rx_EMPTY, 1);
      clr();
      RxD = 1'b0;
      step(4);
      RxD = 1'b1;
      step(12 * 16 * div);
      check("glitch_empty", Rx_EMPTY, 1);
      check("glitch_flags", {Rx_PERROR, Rx_FERROR, Rx_OVF}, 0);
      RxD = 1'b0;
      step(4 * 16 * div);
      Rx_EN = 1'b0;
      RxD = 1'b1;
      step(5);
      Rx_EN = 1'b1;
      step(20);
      send_frame(8'h81, 1'b0, 1'b0);
      check("en_data", Rx_DATA, 'h81);
      pop();
      check("en_only_one", Rx_EMPTY, 1);
      for (int it = 0; it < 16; it++) begin
         int r;
         if ($urandom_range(0, 3) == 0) set_baud(int'($urandom_range(5, 7)));
         repeat ($urandom_range(0, 2)) pop();
         if ($urandom_range(0, 5) == 0) clr();
         step(int'($urandom_range(2, 40)));
         r = int'($urandom_range(0, 5));
         send_frame(8'($urandom_range(0, 255)), r == 0, r == 1);
      end
      repeat (DEPTH + 1) pop();
      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
